// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bus for param_sync_fifo: write side, read side, thresholds, status.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  // Side that uses the FIFO (drives requests and thresholds)
  modport master (
    output wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  full, almost_full, rd_data, empty, almost_empty, level, overflow, underflow
  );

  // The FIFO itself
  modport slave (
    input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output full, almost_full, rd_data, empty, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with generic width/depth, standard or first-word-fall-through
// read, run-time almost thresholds, live level and sticky overflow/underflow.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 8,
  parameter bit FWFT       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  param_sync_fifo_if.slave bus
);
  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come straight off the registered level so they never glitch
  assign w_full   = (r_level == LVL_FULL);
  assign w_empty  = (r_level == '0);
  // Full/empty gate acceptance even when the opposite side is active this cycle
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= bus.af_thresh);
  assign bus.almost_empty = (r_level <= bus.ae_thresh);
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Storage array; deliberately not reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // Pointers wrap naturally at DEPTH; level is tracked separately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a new error event beats a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full)  r_overflow <= 1'b1;
      else if (bus.err_clr)     r_overflow <= 1'b0;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
      else if (bus.err_clr)     r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is exposed combinationally; zero while nothing is stored
      assign bus.rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;

      // Registered read port; holds the last word until the next accepted read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_rd_data <= '0;
        else if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
      end

      assign bus.rd_data = r_rd_data;
    end
  endgenerate
endmodule
